// File: rtl/dmem_access_unit.sv
// Data-memory access stage: turns load/store strobes into a req/ack bus transaction and stalls the core until it retires.
// Optional misaligned-word trap is enabled by defining ALIGN_CHECK_EN.
module dmem_access_unit #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteAccess,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusErr,
    output logic        AlignFault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             byte_acc;
    logic [1:0]       byte_off;
    logic             access;
    logic             misaligned;
    logic [7:0]       rd_lane;

    assign access = MemRead | MemWrite;

`ifdef ALIGN_CHECK_EN
    assign misaligned = !ByteAccess && (ALUResult[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign Stall = ((state == IDLE) && access) || (state == BUS);

    always_comb begin
        rd_lane = mem_rdata[7:0];
        case (byte_off)
            2'd0:    rd_lane = mem_rdata[7:0];
            2'd1:    rd_lane = mem_rdata[15:8];
            2'd2:    rd_lane = mem_rdata[23:16];
            default: rd_lane = mem_rdata[31:24];
        endcase
    end

    // DONE always falls back to IDLE so a held strobe is not re-issued for the same instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
            ReadData   <= 32'h0;
            BusErr     <= 1'b0;
            AlignFault <= 1'b0;
            byte_acc   <= 1'b0;
            byte_off   <= 2'b00;
        end else begin
            BusErr     <= 1'b0;
            AlignFault <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (access) begin
                        if (misaligned) begin
                            state      <= DONE;
                            AlignFault <= 1'b1;
                            ReadData   <= 32'h0;
                        end else begin
                            state    <= BUS;
                            mem_req  <= 1'b1;
                            mem_we   <= MemWrite;
                            mem_addr <= {ALUResult[31:2], 2'b00};
                            byte_acc <= ByteAccess;
                            byte_off <= ALUResult[1:0];
                            if (ByteAccess) begin
                                mem_be    <= 4'b0001 << ALUResult[1:0];
                                mem_wdata <= {4{WriteData[7:0]}};
                            end else begin
                                mem_be    <= 4'b1111;
                                mem_wdata <= WriteData;
                            end
                        end
                    end
                end
                BUS: begin
                    // An ack on the final allowed cycle wins over the timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (mem_we) begin
                            ReadData <= 32'h0;
                        end else if (byte_acc) begin
                            ReadData <= {24'h0, rd_lane};
                        end else begin
                            ReadData <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt == LAST_WAIT) begin
                            mem_req  <= 1'b0;
                            ReadData <= 32'h0;
                            BusErr   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit: loads, stores, byte lanes, timeout, reset abort, alignment.
module tb_dmem_access_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic        ByteAccess;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        BusErr;
    logic        AlignFault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int passes = 0;

    // Results captured by run_access for the calling test to compare.
    int          r_total;
    int          r_stall;
    int          r_req;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_af;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic        r_we;
    logic [31:0] r_wdata;

    dmem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ByteAccess (ByteAccess),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .BusErr     (BusErr),
        .AlignFault (AlignFault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issues one access at a negedge and follows it cycle by cycle until Stall drops (DONE).
    // ack_after = number of BUS cycles before the ack pulse; negative means the slave never acks.
    task automatic run_access(input logic rd, input logic wr, input logic bt, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdat, input int ack_after);
        int n;
        n = 0;
        r_total = 0; r_stall = 0; r_req = 0; r_done = 1'b0;
        r_rdata = 32'hX; r_err = 1'bX; r_af = 1'bX;
        r_addr = 32'h0; r_be = 4'h0; r_we = 1'b0; r_wdata = 32'h0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; ByteAccess = bt; ALUResult = addr; WriteData = wd;
        for (int c = 0; c < 40; c++) begin
            mem_rdata = rdat;
            mem_ack = mem_req && (n == ack_after);
            #1;
            r_total++;
            if (Stall) r_stall++;
            if (mem_req) begin
                if (r_req == 0) begin
                    r_addr = mem_addr; r_be = mem_be; r_we = mem_we; r_wdata = mem_wdata;
                end
                r_req++;
                n++;
            end
            if (!Stall) begin
                r_done = 1'b1;
                r_rdata = ReadData; r_err = BusErr; r_af = AlignFault;
                MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
                break;
            end
            @(negedge clk);
        end
        MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 70'h0) $display("[TB] FAIL reset_bus: got %h want 0", {mem_req, mem_we, mem_addr, mem_be, mem_wdata}); else passes++;
        checks++; if ({ReadData, BusErr, AlignFault, Stall} !== 35'h0) $display("[TB] FAIL reset_status: got %h want 0", {ReadData, BusErr, AlignFault, Stall}); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_word_load();
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 2);
        checks++; if (r_done !== 1'b1) $display("[TB] FAIL word_load_done: got %b want 1", r_done); else passes++;
        checks++; if (r_total !== 5) $display("[TB] FAIL word_load_latency: got %0d want 5", r_total); else passes++;
        checks++; if (r_stall !== 4) $display("[TB] FAIL word_load_stall: got %0d want 4", r_stall); else passes++;
        checks++; if (r_req !== 3) $display("[TB] FAIL word_load_req_cycles: got %0d want 3", r_req); else passes++;
        checks++; if ({r_addr, r_be, r_we} !== {32'h0000_0104, 4'b1111, 1'b0}) $display("[TB] FAIL word_load_bus: got %h/%b/%b want 00000104/1111/0", r_addr, r_be, r_we); else passes++;
        checks++; if (r_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL word_load_rdata: got %h want deadbeef", r_rdata); else passes++;
        checks++; if (r_err !== 1'b0) $display("[TB] FAIL word_load_buserr: got %b want 0", r_err); else passes++;
    endtask

    task automatic test_byte_store();
        run_access(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_56A5, 32'hFFFF_FFFF, 0);
        checks++; if (r_total !== 3) $display("[TB] FAIL byte_store_latency: got %0d want 3", r_total); else passes++;
        checks++; if ({r_addr, r_be, r_we} !== {32'h0000_0200, 4'b1000, 1'b1}) $display("[TB] FAIL byte_store_bus: got %h/%b/%b want 00000200/1000/1", r_addr, r_be, r_we); else passes++;
        checks++; if (r_wdata !== 32'hA5A5_A5A5) $display("[TB] FAIL byte_store_wdata: got %h want a5a5a5a5", r_wdata); else passes++;
        checks++; if (r_rdata !== 32'h0) $display("[TB] FAIL byte_store_rdata: got %h want 0", r_rdata); else passes++;
    endtask

    task automatic test_byte_load();
        run_access(1'b1, 1'b0, 1'b1, 32'h0000_0011, 32'h0, 32'h1122_3344, 1);
        checks++; if (r_total !== 4) $display("[TB] FAIL byte_load_latency: got %0d want 4", r_total); else passes++;
        checks++; if ({r_addr, r_be} !== {32'h0000_0010, 4'b0010}) $display("[TB] FAIL byte_load_bus: got %h/%b want 00000010/0010", r_addr, r_be); else passes++;
        checks++; if (r_rdata !== 32'h0000_0033) $display("[TB] FAIL byte_load_rdata: got %h want 00000033", r_rdata); else passes++;
        mem_rdata = 32'h0;
        @(negedge clk);
        #1;
        checks++; if (ReadData !== 32'h0000_0033) $display("[TB] FAIL rdata_hold: got %h want 00000033", ReadData); else passes++;
        checks++; if ({Stall, mem_req} !== 2'b00) $display("[TB] FAIL idle_quiet: got %b want 00", {Stall, mem_req}); else passes++;
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_0000, -1);
        checks++; if (r_req !== 15) $display("[TB] FAIL timeout_req_cycles: got %0d want 15", r_req); else passes++;
        checks++; if (r_total !== 17) $display("[TB] FAIL timeout_latency: got %0d want 17", r_total); else passes++;
        checks++; if (r_err !== 1'b1) $display("[TB] FAIL timeout_buserr: got %b want 1", r_err); else passes++;
        checks++; if (r_rdata !== 32'h0) $display("[TB] FAIL timeout_rdata: got %h want 0", r_rdata); else passes++;
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        checks++; if ({Stall, BusErr} !== 2'b00) $display("[TB] FAIL buserr_pulse: got %b want 00", {Stall, BusErr}); else passes++;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++; if ({mem_req, Stall, BusErr} !== 3'b000) $display("[TB] FAIL late_ack_ignored: got %b want 000", {mem_req, Stall, BusErr}); else passes++;
    endtask

    task automatic test_ack_at_limit();
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 14);
        checks++; if (r_total !== 17) $display("[TB] FAIL limit_latency: got %0d want 17", r_total); else passes++;
        checks++; if (r_err !== 1'b0) $display("[TB] FAIL limit_buserr: got %b want 0", r_err); else passes++;
        checks++; if (r_rdata !== 32'h0BAD_F00D) $display("[TB] FAIL limit_rdata: got %h want 0badf00d", r_rdata); else passes++;
    endtask

    task automatic test_both_strobes();
        run_access(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h8765_4321, 32'h5555_5555, 0);
        checks++; if ({r_we, r_be, r_wdata} !== {1'b1, 4'b1111, 32'h8765_4321}) $display("[TB] FAIL both_bus: got %b/%b/%h want 1/1111/87654321", r_we, r_be, r_wdata); else passes++;
        checks++; if (r_rdata !== 32'h0) $display("[TB] FAIL both_rdata: got %h want 0", r_rdata); else passes++;
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0, 32'hA1B2_C3D4, 0);
        checks++; if (r_rdata !== 32'h0000_00B2) $display("[TB] FAIL b2b_first_rdata: got %h want 000000b2", r_rdata); else passes++;
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 32'h0102_0304, 1);
        checks++; if (r_total !== 4) $display("[TB] FAIL b2b_second_latency: got %0d want 4", r_total); else passes++;
        checks++; if ({r_addr, r_rdata} !== {32'h0000_0024, 32'h0102_0304}) $display("[TB] FAIL b2b_second: got %h/%h want 00000024/01020304", r_addr, r_rdata); else passes++;
    endtask

    task automatic test_alignment();
`ifdef ALIGN_CHECK_EN
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 32'h7777_7777, 0);
        checks++; if (r_req !== 0) $display("[TB] FAIL align_no_req: got %0d want 0", r_req); else passes++;
        checks++; if ({r_total, r_stall} !== {32'd2, 32'd1}) $display("[TB] FAIL align_timing: got %0d/%0d want 2/1", r_total, r_stall); else passes++;
        checks++; if ({r_af, r_rdata} !== {1'b1, 32'h0}) $display("[TB] FAIL align_fault: got %b/%h want 1/0", r_af, r_rdata); else passes++;
`else
        run_access(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 32'h7777_7777, 0);
        checks++; if ({r_addr, r_be} !== {32'h0000_0100, 4'b1111}) $display("[TB] FAIL misaligned_bus: got %h/%b want 00000100/1111", r_addr, r_be); else passes++;
        checks++; if ({r_af, r_rdata, r_total} !== {1'b0, 32'h7777_7777, 32'd3}) $display("[TB] FAIL misaligned_result: got %b/%h/%0d want 0/77777777/3", r_af, r_rdata, r_total); else passes++;
`endif
        run_access(1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h99AA_BBCC, 0);
        checks++; if ({r_af, r_be, r_rdata} !== {1'b0, 4'b0100, 32'h0000_00AA}) $display("[TB] FAIL byte_never_faults: got %b/%b/%h want 0/0100/000000aa", r_af, r_be, r_rdata); else passes++;
    endtask

    task automatic test_reset_in_bus();
        @(negedge clk);
        MemRead = 1'b1; ByteAccess = 1'b0; ALUResult = 32'h0000_0500; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if ({mem_req, Stall} !== 2'b11) $display("[TB] FAIL rst_bus_pre: got %b want 11", {mem_req, Stall}); else passes++;
        reset = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        #1;
        checks++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData, BusErr, AlignFault, Stall} !== 105'h0) $display("[TB] FAIL rst_bus_abort: got %h want 0", {mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData, BusErr, AlignFault, Stall}); else passes++;
        reset = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++; if ({mem_req, Stall, ReadData} !== 34'h0) $display("[TB] FAIL rst_late_ack: got %h want 0", {mem_req, Stall, ReadData}); else passes++;
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ByteAccess = 1'b0;
        ALUResult = 32'h0; WriteData = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_timeout();
        test_ack_at_limit();
        test_both_strobes();
        test_back_to_back();
        test_alignment();
        test_reset_in_bus();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Data-memory access stage directly downstream of the single-cycle datapath.
- Consumes ALUResult (address) and WriteData on loads and stores.
- Drives a variable-latency memory bus with a req/ack handshake and returns ReadData to the result mux.
- Asserts Stall, which the top level uses to freeze the PC register and RegWrite until the access retires.

Parameters:
- MAX_WAIT, 15: bus cycles without ack before the access is aborted with BusErr.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MemRead  input  1  current instruction is a load.
- MemWrite  input  1  current instruction is a store.
- ByteAccess  input  1  1 = byte access (LDRB/STRB), 0 = word access.
- ALUResult  input  32  effective byte address.
- WriteData  input  32  store data; bits [7:0] are used for byte stores.
- ReadData  output  32  load result, valid in the DONE cycle.
- Stall  output  1  hold the pipeline: PC and register file must not update.
- BusErr  output  1  one-cycle pulse in DONE when the access timed out.
- AlignFault  output  1  one-cycle pulse in DONE on a misaligned word access (optional feature).
- mem_req  output  1  bus request; held until ack or timeout.
- mem_we  output  1  1 = write transaction.
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
- mem_be  output  4  byte-lane enables.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data, sampled when mem_ack=1.
- mem_ack  input  1  transaction complete; single-cycle pulse from the slave.

Behaviour:
- FSM states: IDLE, BUS, DONE.
- Reset (synchronous):
  - state=IDLE; wait counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - ReadData=0, BusErr=0, AlignFault=0.
  - Reset asserted in BUS abandons the transaction: mem_req is 0 on the next cycle and any later ack is ignored.
- Stall, combinational: (state==IDLE & (MemRead|MemWrite)) | state==BUS. Stall is 0 in DONE and in IDLE with no access.
- IDLE:
  - If MemRead|MemWrite, go to BUS and latch the request:
    - mem_addr = {ALUResult[31:2],2'b00}.
    - mem_we = MemWrite. Write wins if both strobes are high; ReadData is then 0.
    - Word access: mem_be=4'b1111, mem_wdata=WriteData.
    - Byte access: mem_be = 4'b0001 << ALUResult[1:0], mem_wdata = {4{WriteData[7:0]}}.
  - Clear the wait counter.
  - mem_req goes high on the first BUS cycle (registered).
  - mem_ack seen while in IDLE or DONE is ignored.
- BUS:
  - mem_req=1; mem_ack is sampled each cycle.
  - On ack:
    - Read: capture ReadData. Word access = mem_rdata. Byte access = zero-extended lane mem_rdata[8*a+7:8*a], where a = latched addr[1:0].
    - Write: ReadData=0.
    - Drop mem_req and go to DONE.
  - No ack: increment the counter. When the counter equals MAX_WAIT (i.e., MAX_WAIT cycles in BUS without ack), drop mem_req, set ReadData=0, go to DONE with BusErr=1.
  - Ack arriving in the same cycle the counter hits MAX_WAIT counts as success; BusErr=0.
- DONE:
  - Exactly one cycle with Stall=0, so the instruction retires and the PC advances at the end of this cycle.
  - BusErr and AlignFault pulse only here.
  - Unconditionally go to IDLE, so the same instruction's strobes are never re-issued.
- ReadData holds its last value between accesses.
- Latency:
  - Access with ack k cycles after mem_req rises (k=0 means ack on the first BUS cycle) takes 3+k cycles from IDLE to DONE inclusive.
  - Back-to-back memory instructions are separated by exactly one IDLE cycle.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: a word access with ALUResult[1:0] != 0 issues no bus transaction. The FSM goes IDLE->DONE directly with AlignFault=1 and ReadData=0; Stall is 1 only for the IDLE cycle. Byte accesses are never faulted.
- Undefined: AlignFault is tied to 0. Misaligned word accesses silently use the aligned address with mem_be=4'b1111.

Test Plan:
- Word load, ALUResult=0x00000104, slave acks 2 cycles after req, mem_rdata=0xDEADBEEF -> mem_addr=0x104, mem_be=4'b1111, mem_we=0. Stall high for 4 cycles. ReadData=0xDEADBEEF in DONE with Stall=0.
- Byte store, ALUResult=0x00000203, WriteData=0x123456A5, ack immediate -> mem_addr=0x200, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1. DONE reached 3 cycles after the request.
- Byte load, ALUResult=0x00000011, mem_rdata=0x11223344 -> ReadData=0x00000033.
- No ack, MAX_WAIT=15 -> mem_req high for exactly 15 cycles, then DONE with BusErr=1, ReadData=0. A late ack in IDLE is ignored: no state change, no new req.
- Reset asserted on the 3rd BUS cycle -> next cycle state=IDLE, mem_req=0, Stall=0 (strobes low), all outputs 0.
- With ALIGN_CHECK_EN, word load at 0x00000102 -> mem_req never asserts, AlignFault=1 for one cycle, Stall high 1 cycle. Without the macro, an aligned read at 0x100 is performed.
